// File: rtl/sync_multi_filter_pkg.sv
// sync_pkg: shared constants and counter-width helper for the multi-channel synchroniser.
package sync_pkg;
    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_MAX_STAGES = 4;

    function automatic int cnt_width(input int filt_cycles);
        return ($clog2(filt_cycles + 1) < 1) ? 1 : $clog2(filt_cycles + 1);
    endfunction
endpackage

// File: rtl/sync_multi_filter_if.sv
// sync_multi_filter_if: asynchronous pin inputs and synchronised/filtered outputs.
interface sync_multi_filter_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    modport master (output async_in, input meta, sync_out, filt_out, rise, fall);
    modport slave (input async_in, output meta, sync_out, filt_out, rise, fall);
endinterface

// File: rtl/sync_multi_filter_chan_filter.sv
// sync_chan_filter: one channel of flop chain, debounce counter and edge pulses.
module sync_chan_filter
    import sync_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter logic RST_BIT     = 1'b0,
    parameter int   FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic meta,
    output logic sync_out,
    output logic filt_out,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] stage;
    logic filt_next;

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) stage <= {STAGES{RST_BIT}};
        else stage <= {stage[STAGES-2:0], async_in};

    assign meta = stage[0];
    assign sync_out = stage[STAGES-1];

    if (FILT_CYCLES <= 1) begin : g_nofilt
        assign filt_next = sync_out;
    end else begin : g_filt
        localparam int CNT_W = cnt_width(FILT_CYCLES);
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);
        logic [CNT_W-1:0] cnt;
        logic done;
        // any return to the old level restarts the stability count
        assign done = (sync_out != filt_out) && (cnt == CNT_MAX);
        assign filt_next = done ? sync_out : filt_out;
        always_ff @(posedge clk or negedge n_rst)
            if (!n_rst) cnt <= '0;
            else cnt <= (sync_out == filt_out || done) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            filt_out <= RST_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            filt_out <= filt_next;
            rise <= filt_next & ~filt_out;
            fall <= ~filt_next & filt_out;
        end
endmodule

// File: rtl/sync_multi_filter.sv
// sync_multi_filter: WIDTH independent synchroniser/debounce channels with rise/fall pulses.
module sync_multi_filter
    import sync_pkg::*;
#(
    parameter int             WIDTH       = 4,
    parameter int             STAGES      = 2,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter int             FILT_CYCLES = 4
) (
    input logic clk,
    input logic n_rst,
    sync_multi_filter_if.slave bus
);
    logic [WIDTH-1:0] meta, sync_out, filt_out, rise, fall;

    if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
        $error("sync_multi_filter: STAGES must be within 2..4");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_chan_filter #(
            .STAGES(STAGES),
            .RST_BIT(RST_VAL[i]),
            .FILT_CYCLES(FILT_CYCLES)
        ) u_ch (
            .clk(clk),
            .n_rst(n_rst),
            .async_in(bus.async_in[i]),
            .meta(meta[i]),
            .sync_out(sync_out[i]),
            .filt_out(filt_out[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end

    assign bus.meta = meta;
    assign bus.sync_out = sync_out;
    assign bus.filt_out = filt_out;
    assign bus.rise = rise;
    assign bus.fall = fall;
endmodule
